// File: rtl/tx_uart.sv
// tx_uart: byte-at-a-time UART transmitter, 8N1 framing by default.
// Define TX_UART_PARITY_EN to add an even parity bit after the data (8E1).
// A byte is accepted on any rising edge with i_wr high while not busy; the
// serial output is a flop so the pin never glitches.
module tx_uart #(
    parameter int CLOCKS_PER_BAUD = 868,
    parameter int TIMER_BITS      = 32
) (
    input  logic       clk,
    input  logic       i_reset_n,
    input  logic       i_wr,
    input  logic [7:0] i_data,
    output logic       out_busy,
    output logic       uart_rxd_out
);

`ifdef TX_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    localparam logic [TIMER_BITS-1:0] RELOAD = TIMER_BITS'(CLOCKS_PER_BAUD - 1);

    state_t                state, state_d;
    logic [TIMER_BITS-1:0] cnt, cnt_d;
    logic [7:0]            shift, shift_d;
    logic [2:0]            idx, idx_d;
    logic                  line, line_d;
    logic                  busy, busy_d;
    logic                  tick;
`ifdef TX_UART_PARITY_EN
    logic                  par, par_d;
`endif

    assign tick         = (cnt == '0);
    assign out_busy     = busy;
    assign uart_rxd_out = line;

    // State, timer, shifter and registered pin update.
    always_ff @(posedge clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            shift <= '0;
            idx   <= '0;
            line  <= 1'b1;
            busy  <= 1'b0;
`ifdef TX_UART_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            shift <= shift_d;
            idx   <= idx_d;
            line  <= line_d;
            busy  <= busy_d;
`ifdef TX_UART_PARITY_EN
            par   <= par_d;
`endif
        end
    end

    // Next-state logic: every bit boundary is the cycle the timer sits at 0,
    // so each bit is exactly CLOCKS_PER_BAUD cycles long.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        shift_d = shift;
        idx_d   = idx;
        line_d  = line;
        busy_d  = busy;
`ifdef TX_UART_PARITY_EN
        par_d   = par;
`endif
        if (state != IDLE)
            cnt_d = tick ? RELOAD : cnt - TIMER_BITS'(1);

        case (state)
            IDLE: begin
                if (i_wr && !busy) begin
                    shift_d = i_data;
                    cnt_d   = RELOAD;
                    line_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = START;
`ifdef TX_UART_PARITY_EN
                    par_d   = ^i_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    line_d  = shift[0];
                    shift_d = shift >> 1;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (idx == 3'd7) begin
`ifdef TX_UART_PARITY_EN
                        line_d  = par;
                        state_d = PARITY;
`else
                        line_d  = 1'b1;
                        state_d = STOP;
`endif
                    end else begin
                        line_d  = shift[0];
                        shift_d = shift >> 1;
                        idx_d   = idx + 3'd1;
                    end
                end
            end
`ifdef TX_UART_PARITY_EN
            PARITY: begin
                if (tick) begin
                    line_d  = 1'b1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: random-byte bench for tx_uart at 8 clocks per bit. The expected
// line level for each cycle of a frame is taken from the frame bit list.
module tb_tx_uart;

    localparam int N = 8;
`ifdef TX_UART_PARITY_EN
    localparam int FR = 11;
    localparam bit PAR = 1'b1;
`else
    localparam int FR = 10;
    localparam bit PAR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_reset_n;
    logic       i_wr;
    logic [7:0] i_data;
    logic       out_busy;
    logic       uart_rxd_out;

    int n_chk  = 0;
    int n_pass = 0;

    tx_uart #(.CLOCKS_PER_BAUD(N), .TIMER_BITS(8)) dut (
        .clk          (clk),
        .i_reset_n    (i_reset_n),
        .i_wr         (i_wr),
        .i_data       (i_data),
        .out_busy     (out_busy),
        .uart_rxd_out (uart_rxd_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Line level t cycles after the accepting edge: frame bit t/N, where
    // bit 0 is start, 1..8 data LSB first, then optional parity, then stop.
    function automatic logic exp_line(input logic [7:0] b, input int t);
        int k;
        k = t / N;
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (PAR && k == 9) return ^b;
        return 1'b1;
    endfunction

    // Called on a falling edge with the transmitter idle. Checks every cycle
    // of the frame. intf: cycle at which a rejected write is pulsed (-1 none);
    // chain: keep i_wr high so the next call starts back-to-back;
    // abort_at: cycle at which reset is asserted asynchronously (-1 none).
    task automatic send(input logic [7:0] b, input int intf, input bit chain, input int abort_at);
        i_wr   = 1'b1;
        i_data = b;
        @(posedge clk);
        for (int t = 0; t < FR * N; t++) begin
            @(negedge clk);
            if (t == 0) begin
                if (chain) i_data = 8'($urandom);
                else       i_wr   = 1'b0;
            end
            if (t == intf) begin
                i_wr   = 1'b1;
                i_data = ~b;
            end
            if (t == intf + 1 && !chain) i_wr = 1'b0;
            chk("line", uart_rxd_out, exp_line(b, t));
            chk("busy", out_busy, 1);
            if (t == abort_at) begin
                i_reset_n = 1'b0;
                #1;
                chk("abort_line", uart_rxd_out, 1);
                chk("abort_busy", out_busy, 0);
                repeat (2) begin
                    @(negedge clk);
                    chk("abort_hold_line", uart_rxd_out, 1);
                end
                i_reset_n = 1'b1;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        chk("done_busy", out_busy, 0);
        chk("stop_line", uart_rxd_out, 1);
    endtask

    task automatic idle(input int n);
        i_wr = 1'b0;
        repeat (n) begin
            @(negedge clk);
            chk("idle_line", uart_rxd_out, 1);
            chk("idle_busy", out_busy, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        int         intf;
        bit         ch;

        // Reset held with a pending write: nothing may start.
        i_reset_n = 1'b0;
        i_wr      = 1'b1;
        i_data    = 8'h3C;
        repeat (5) begin
            @(negedge clk);
            chk("rst_line", uart_rxd_out, 1);
            chk("rst_busy", out_busy, 0);
        end
        i_reset_n = 1'b1;

        // First edge after release accepts 0x41.
        send(8'h41, -1, 1'b0, -1);
        idle(5);

        // Write during busy is dropped; no second frame follows.
        send(8'h55, 20, 1'b0, -1);
        idle(30);

        // Back-to-back with i_wr held: second start at E0+10N+1.
        send(8'h00, -1, 1'b1, -1);
        send(8'hFF, -1, 1'b0, -1);
        idle(3);

        // Async reset during data bit 3, then a clean frame.
        send(8'h00, -1, 1'b0, 4 * N + 3);
        idle(2);
        send(8'hA5, -1, 1'b0, -1);
        idle(2);
        send(8'h43, -1, 1'b0, -1);
        idle(2);

        // Random bytes, random rejected writes, random chaining.
        for (int i = 0; i < 12; i++) begin
            b    = 8'($urandom);
            ch   = (i != 11) && ($urandom_range(0, 2) == 0);
            intf = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, FR * N - 3)) : -1;
            send(b, intf, ch, -1);
            if (!ch) idle(int'($urandom_range(1, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
